pulse_delay_array: RTL

- Multi-channel, run-time-programmable pulse delay line; next generation of the single-channel LVDS pulse sampler.
- Each of CHANNELS synchronous pulse inputs is edge-detected, stored in one shared circular buffer (CHANNELS bits wide, MAX_DELAY deep) and replayed as a 1-cycle pulse after delay_cfg cycles.
- Sits between the input buffers / edge-sync stage and the TTL output pins.
- An FSM controls fill, run and reconfiguration.

---
 rtl/pulse_delay_array_pkg.sv | 20 ++
 rtl/pulse_ring_buffer.sv | 26 ++
 rtl/pulse_delay_array.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pulse_delay_array_pkg.sv
// Shared types and helpers for the multi-channel pulse delay array.
// Holds the FSM state encoding and the delay clamp used on cfg loads.
package sampler_pkg;

  localparam int unsigned MIN_DELAY = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Delays below the minimum collapse to the minimum.
  function automatic int unsigned clamp_delay(
    input int unsigned d
  );
    return (d < MIN_DELAY) ? MIN_DELAY : d;
  endfunction

endpackage

// File: rtl/pulse_ring_buffer.sv
// Circular pulse store: one write and one registered read per cycle.
// No reset on the array or read register so it maps onto block/LUT RAM.
module pulse_ring_buffer #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_ptr,
  input  logic [AW-1:0]    rd_ptr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Synchronous write and registered read of the ring.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wr_ptr] <= din;
    end
    dout <= r_mem[rd_ptr];
  end

endmodule

// File: rtl/pulse_delay_array.sv
// Multi-channel programmable pulse delay line with fill/run FSM.
// Optional macro PULSE_STRETCH_EN widens each output pulse to STRETCH cycles.
module pulse_delay_array
  import sampler_pkg::*;
#(
  parameter int CHANNELS    = 16,
  parameter int MAX_DELAY   = 256,
  parameter int DELAY_WIDTH = $clog2(MAX_DELAY),
  parameter int STRETCH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS-1:0]    pulse_in,
  input  logic                   enable,
  input  logic                   cfg_load,
  input  logic [DELAY_WIDTH-1:0] delay_cfg,
  output logic [CHANNELS-1:0]    pulse_out,
  output logic                   filling,
  output logic                   running,
  output logic                   cfg_err
);

  if (STRETCH < 1 || MAX_DELAY < 4 ||
      (MAX_DELAY & (MAX_DELAY - 1)) != 0) begin : g_param_err
    $error("pulse_delay_array: bad STRETCH or MAX_DELAY");
  end

  localparam logic [DELAY_WIDTH-1:0] ONE = DELAY_WIDTH'(1);
  localparam logic [DELAY_WIDTH-1:0] HALF =
    DELAY_WIDTH'(MAX_DELAY / 2);

  state_t r_state;
  state_t w_state_nxt;

  logic [CHANNELS-1:0]    r_prev;
  logic [CHANNELS-1:0]    r_det;
  logic [CHANNELS-1:0]    w_rd_data;
  logic [DELAY_WIDTH-1:0] r_wr_ptr;
  logic [DELAY_WIDTH-1:0] w_rd_ptr;
  logic [DELAY_WIDTH-1:0] r_delay;
  logic [DELAY_WIDTH-1:0] r_fill_cnt;
  logic                   r_out_en;
  logic                   r_cfg_err;
  logic                   w_we;

  assign w_we     = (r_state == FILL) || (r_state == RUN);
  assign w_rd_ptr = r_wr_ptr - r_delay;

  // Rising-edge detect; history starts high so reset creates no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '1;
      r_det  <= '0;
    end else begin
      r_prev <= pulse_in;
      r_det  <= pulse_in & ~r_prev;
    end
  end

  // Write pointer walks the ring whenever the line is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_we) begin
      r_wr_ptr <= r_wr_ptr + ONE;
    end
  end

  pulse_ring_buffer #(
    .WIDTH (CHANNELS),
    .DEPTH (MAX_DELAY)
  ) u_ring (
    .clk    (clk),
    .we     (w_we),
    .wr_ptr (r_wr_ptr),
    .rd_ptr (w_rd_ptr),
    .din    (r_det),
    .dout   (w_rd_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: FILL spans exactly r_delay cycles.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (r_fill_cnt == r_delay - ONE) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Fill counter runs only in FILL and restarts from zero on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_cnt <= '0;
    end else if (r_state == FILL) begin
      r_fill_cnt <= r_fill_cnt + ONE;
    end else begin
      r_fill_cnt <= '0;
    end
  end

  // Delay loads only while idle; busy loads raise a one-cycle error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_delay   <= HALF;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_load && (r_state != IDLE);
      if (cfg_load && (r_state == IDLE)) begin
        r_delay <= DELAY_WIDTH'(clamp_delay(32'(delay_cfg)));
      end
    end
  end

  // The read register lags the pointers by one cycle, so the first
  // RUN cycle still shows the slot behind the fill start; gate it off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_en <= 1'b0;
    end else begin
      r_out_en <= (r_state == RUN) && (w_state_nxt == RUN);
    end
  end

`ifdef PULSE_STRETCH_EN
  localparam int CNT_W = $clog2(STRETCH + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH - 1);

  logic [CNT_W-1:0]    r_cnt [CHANNELS];
  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_hold;

  assign w_hit = w_rd_data & {CHANNELS{r_out_en}};

  // Per-channel hold counters; a fresh hit retriggers the stretch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (r_state == IDLE) begin
          r_cnt[i] <= '0;
        end else if (w_hit[i]) begin
          r_cnt[i] <= RELOAD;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Channel stays high while its counter has cycles left.
  always_comb begin
    w_hold = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_hold[i] = (r_cnt[i] != '0);
    end
  end

  assign pulse_out = (w_hit | w_hold) & {CHANNELS{r_out_en}};
`else
  assign pulse_out = w_rd_data & {CHANNELS{r_out_en}};
`endif

  assign filling = (r_state == FILL);
  assign running = (r_state == RUN);
  assign cfg_err = r_cfg_err;

endmodule
